gate_panel: RTL and testbench



---
 rtl/gate_panel_pkg.sv | 40 ++++
 rtl/gate_panel_sync_debounce.sv | 59 +++++
 rtl/gate_panel.sv | 94 +++++++++
 tb/tb_gate_panel.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_panel_pkg.sv
// Shared types and helpers for the gate panel: gate mode encoding and advance order.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   gate_mode_e   - 3-bit gate function code shown on the mode LEDs
//   mode_count_lp - number of reachable gate modes
//   next_mode()   - successor of a mode in the button-advance sequence
package gate_panel_pkg;

    // Encodings 6 and 7 are never produced by next_mode(). If one ever appears
    // (e.g. an upset), it is evaluated as AND and the next advance returns to AND.
    typedef enum logic [2:0] {
        MODE_AND  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_XOR  = 3'd2,
        MODE_NAND = 3'd3,
        MODE_NOR  = 3'd4,
        MODE_XNOR = 3'd5
    } gate_mode_e;

    localparam int mode_count_lp = 6;

    // AND -> OR -> XOR -> NAND -> NOR -> XNOR -> AND. Any out-of-range code
    // recovers to AND.
    function automatic gate_mode_e next_mode(input gate_mode_e mode);
        gate_mode_e nxt;
        case (mode)
            MODE_AND:  nxt = MODE_OR;
            MODE_OR:   nxt = MODE_XOR;
            MODE_XOR:  nxt = MODE_NAND;
            MODE_NAND: nxt = MODE_NOR;
            MODE_NOR:  nxt = MODE_XNOR;
            MODE_XNOR: nxt = MODE_AND;
            default:   nxt = MODE_AND;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/gate_panel_sync_debounce.sv
// One-bit synchroniser plus debouncer for a raw board button or switch.
// Latency: a settled input reaches a_o debounce_cycles_p+2 edges after it is first sampled.
// Backpressure: none; free-running, consumes its input every cycle.
//
// Ports:
//   clk_i      - single clock domain
//   reset_i    - synchronous, active-high; clears synchroniser, counter and stable value
//   a_async_i  - raw asynchronous input
//   a_o        - debounced stable value (registered)
module sync_debounce
    import gate_panel_pkg::*;
#(
    parameter int debounce_cycles_p = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic a_async_i,
    output logic a_o
);

    // Counter only ever needs to reach debounce_cycles_p-1; guard the width so
    // the smallest legal setting (2) still gets a 1-bit counter.
    localparam int cnt_w_lp = (debounce_cycles_p > 2) ? $clog2(debounce_cycles_p) : 1;
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(debounce_cycles_p - 1);

    logic                meta_r;    // first synchroniser stage, may go metastable
    logic                sync_r;    // second stage, safe to use in logic
    logic                stable_r;  // last accepted (debounced) value
    logic [cnt_w_lp-1:0] cnt_r;     // consecutive edges that sync_r has disagreed with stable_r

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_r   <= 1'b0;
            sync_r   <= 1'b0;
            stable_r <= 1'b0;
            cnt_r    <= '0;
        end else begin
            meta_r <= a_async_i;
            sync_r <= meta_r;

            if (sync_r != stable_r) begin
                // The disagreement must persist for debounce_cycles_p edges in a
                // row; the last of those edges accepts the new value.
                if (cnt_r == cnt_last_lp) begin
                    stable_r <= sync_r;
                    cnt_r    <= '0;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end else begin
                // Any agreement restarts the run, so short glitches are dropped.
                cnt_r <= '0;
            end
        end
    end

    assign a_o = stable_r;

endmodule

// File: rtl/gate_panel.sv
// N-input logic-gate panel with a button-selected gate function driving an LED.
// Latency: settled input -> result_o in debounce_cycles_p+3 edges; mode press -> mode_o in debounce_cycles_p+3.
// Backpressure: none; every input is sampled each cycle and outputs are plain registers.
//
// Ports:
//   clk_i         - single clock domain
//   reset_i       - synchronous, active-high reset
//   in_async_i    - width_p raw gate inputs (asynchronous, bouncy)
//   mode_async_i  - raw mode-advance button, active-high (asynchronous, bouncy)
//   result_o      - registered gate function over all debounced inputs
//   mode_o        - current gate mode, gate_mode_e encoding
module gate_panel
    import gate_panel_pkg::*;
#(
    parameter int width_p           = 2,   // legal 2..8
    parameter int debounce_cycles_p = 16   // legal 2..2**24
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] in_async_i,
    input  logic               mode_async_i,
    output logic               result_o,
    output logic [2:0]         mode_o
);

    logic [width_p-1:0] in_stable;    // debounced gate inputs
    logic               mode_stable;  // debounced mode button
    logic               mode_prev_r;  // mode_stable one edge ago, for edge detection
    gate_mode_e         mode_r;
    logic               result_r;
    logic               gate_val;
    logic               mode_rise;

    // One synchroniser/debouncer per gate input.
    for (genvar i = 0; i < width_p; i++) begin : g_in_db
        sync_debounce #(
            .debounce_cycles_p (debounce_cycles_p)
        ) u_in_db (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .a_async_i (in_async_i[i]),
            .a_o       (in_stable[i])
        );
    end

    // The mode button gets the same treatment so one press is one clean edge.
    sync_debounce #(
        .debounce_cycles_p (debounce_cycles_p)
    ) u_mode_db (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .a_async_i (mode_async_i),
        .a_o       (mode_stable)
    );

    // Only the press (0->1) advances; holding or releasing does nothing.
    assign mode_rise = mode_stable & ~mode_prev_r;

    // Gate function over the stable inputs under the current mode. Unreachable
    // codes fall back to AND.
    always_comb begin
        gate_val = &in_stable;
        case (mode_r)
            MODE_AND:  gate_val =  (&in_stable);
            MODE_OR:   gate_val =  (|in_stable);
            MODE_XOR:  gate_val =  (^in_stable);
            MODE_NAND: gate_val = ~(&in_stable);
            MODE_NOR:  gate_val = ~(|in_stable);
            MODE_XNOR: gate_val = ~(^in_stable);
            default:   gate_val =  (&in_stable);
        endcase
    end

    // Mode and result are updated together from the same pre-edge values, so an
    // input change and a mode advance landing on one edge are both kept: the
    // following edge computes the new inputs under the new mode.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mode_prev_r <= 1'b0;
            mode_r      <= MODE_AND;
            result_r    <= 1'b0;
        end else begin
            mode_prev_r <= mode_stable;
            if (mode_rise) begin
                mode_r <= next_mode(mode_r);
            end
            result_r <= gate_val;
        end
    end

    assign result_o = result_r;
    assign mode_o   = mode_r;

endmodule

// File: tb/tb_gate_panel.sv
module tb_gate_panel;

    localparam int W = 3;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic [W-1:0] in_async_i = '0;
    logic         mode_async_i = 1'b0;
    logic         result_o;
    logic [2:0]   mode_o;

    always #5 clk = ~clk;

    gate_panel #(
        .width_p           (W),
        .debounce_cycles_p (N)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .in_async_i   (in_async_i),
        .mode_async_i (mode_async_i),
        .result_o     (result_o),
        .mode_o       (mode_o)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cur_mode    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: gate result from the count of ones, the mode as an
    // integer stepped modulo 6, debouncing as "the 2-edge-old sample must
    // disagree with the accepted value for N edges in a row".
    // ------------------------------------------------------------------
    logic [3:0] hist1 = '0;   // raw {mode, in} sampled at the previous edge
    logic [3:0] hist2 = '0;   // raw {mode, in} sampled two edges ago
    logic [3:0] m_stable = '0;
    int         m_run[4] = '{0, 0, 0, 0};
    int         m_mode = 0;
    logic       m_prev = 1'b0;
    logic       m_result = 1'b0;

    function automatic logic gate_ref(input int mode, input logic [W-1:0] v);
        int ones;
        ones = $countones(v);
        case (mode)
            0:       return ones == W;
            1:       return ones != 0;
            2:       return (ones % 2) == 1;
            3:       return ones != W;
            4:       return ones == 0;
            5:       return (ones % 2) == 0;
            default: return ones == W;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset_i) begin
            hist1    = '0;
            hist2    = '0;
            m_stable = '0;
            for (int b = 0; b < 4; b++) m_run[b] = 0;
            m_mode   = 0;
            m_prev   = 1'b0;
            m_result = 1'b0;
        end else begin
            m_result = gate_ref(m_mode, m_stable[W-1:0]);
            if (m_stable[3] && !m_prev) m_mode = (m_mode + 1) % 6;
            m_prev = m_stable[3];
            for (int b = 0; b < 4; b++) begin
                if (hist2[b] != m_stable[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == N) begin
                        m_stable[b] = hist2[b];
                        m_run[b]    = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            hist2 = hist1;
            hist1 = {mode_async_i, in_async_i};
        end
    end

    // One clean press: 8 cycles high, 8 low.
    task automatic press();
        mode_async_i = 1'b1;
        repeat (8) tick();
        mode_async_i = 1'b0;
        repeat (8) tick();
    endtask

    task automatic press_to(input int target);
        int n;
        n = (target - cur_mode + 6) % 6;
        repeat (n) press();
        cur_mode = target;
    endtask

    typedef struct {
        logic [W-1:0] in;
        int           mode;
        logic         exp;
    } vec_t;

    vec_t tbl[12];
    int   exp_cycle[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int in_hold;
        int mode_hold;

        tbl[0]  = '{3'b111, 0, 1'b1};
        tbl[1]  = '{3'b110, 0, 1'b0};
        tbl[2]  = '{3'b000, 1, 1'b0};
        tbl[3]  = '{3'b100, 1, 1'b1};
        tbl[4]  = '{3'b110, 2, 1'b0};
        tbl[5]  = '{3'b111, 2, 1'b1};
        tbl[6]  = '{3'b111, 3, 1'b0};
        tbl[7]  = '{3'b010, 3, 1'b1};
        tbl[8]  = '{3'b000, 4, 1'b1};
        tbl[9]  = '{3'b001, 4, 1'b0};
        tbl[10] = '{3'b011, 5, 1'b1};
        tbl[11] = '{3'b001, 5, 1'b0};
        exp_cycle = '{1, 0, 1, 0, 1, 0};

        // Reset held 3 cycles with all inputs high.
        reset_i    = 1'b1;
        in_async_i = 3'b111;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("reset_result_e%0d", k), result_o, 0);
            check($sformatf("reset_mode_e%0d", k), mode_o, 0);
        end
        reset_i = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("release_result_e%0d", k), result_o, (k >= 7) ? 1 : 0);
        end

        // Debounce latency: 111 -> 011 just before edge 1.
        in_async_i = 3'b011;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("latency_e%0d", k), result_o, (k < 7) ? 1 : 0);
        end

        // 3-cycle glitch is rejected.
        in_async_i = 3'b111;
        repeat (10) tick();
        in_async_i = 3'b110;
        repeat (3) tick();
        in_async_i = 3'b111;
        for (int k = 4; k <= 15; k++) begin
            tick();
            check($sformatf("glitch3_e%0d", k), result_o, 1);
        end

        // 4-cycle pulse passes: result low on edges 7..10.
        in_async_i = 3'b110;
        repeat (4) tick();
        in_async_i = 3'b111;
        for (int k = 5; k <= 16; k++) begin
            tick();
            check($sformatf("pulse4_e%0d", k), result_o, (k >= 7 && k <= 10) ? 0 : 1);
        end

        // Full mode cycle with inputs 110.
        in_async_i = 3'b110;
        repeat (10) tick();
        check("cycle_start_mode", mode_o, 0);
        check("cycle_start_result", result_o, 0);
        for (int i = 0; i < 6; i++) begin
            press();
            check($sformatf("cycle_mode_%0d", i), mode_o, (i + 1) % 6);
            check($sformatf("cycle_result_%0d", i), result_o, exp_cycle[i]);
        end
        cur_mode = 0;

        // Table of steady-state gate results.
        for (int i = 0; i < 12; i++) begin
            in_async_i = tbl[i].in;
            press_to(tbl[i].mode);
            repeat (10) tick();
            check($sformatf("tbl%0d_mode", i), mode_o, tbl[i].mode);
            check($sformatf("tbl%0d_result", i), result_o, tbl[i].exp);
        end

        // Simultaneous input change and mode press from OR/000.
        in_async_i = 3'b000;
        press_to(1);
        repeat (10) tick();
        check("simul_pre_mode", mode_o, 1);
        check("simul_pre_result", result_o, 0);
        in_async_i   = 3'b001;
        mode_async_i = 1'b1;
        repeat (6) tick();
        check("simul_e6_mode", mode_o, 1);
        tick();
        check("simul_e7_mode", mode_o, 2);
        check("simul_e7_result", result_o, 1);
        tick();
        check("simul_e8_result", result_o, 1);
        mode_async_i = 1'b0;
        repeat (8) tick();
        cur_mode = 2;

        // Reset two cycles into a debounce.
        in_async_i = 3'b101;
        repeat (10) tick();
        in_async_i = 3'b111;
        repeat (4) tick();
        reset_i = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            check($sformatf("midreset_mode_%0d", k), mode_o, 0);
            check($sformatf("midreset_result_%0d", k), result_o, 0);
        end
        reset_i = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("midreset_release_e%0d", k), result_o, (k >= 7) ? 1 : 0);
        end
        cur_mode = 0;

        // Randomised run against the reference model.
        in_hold   = 0;
        mode_hold = 0;
        for (int c = 0; c < 2500; c++) begin
            if (in_hold == 0) begin
                in_async_i = W'($urandom_range(0, 7));
                in_hold    = $urandom_range(1, 10);
            end
            if (mode_hold == 0) begin
                mode_async_i = ~mode_async_i;
                mode_hold    = $urandom_range(1, 12);
            end
            in_hold--;
            mode_hold--;
            reset_i = ($urandom_range(0, 399) == 0);
            tick();
            check("rand_result", result_o, m_result);
            check("rand_mode", mode_o, m_mode);
        end
        reset_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
